ccu_line_arbiter: RTL and testbench



---
 rtl/ccu_line_arbiter.sv | 147 ++++++++++++++
 tb/tb_ccu_line_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ccu_line_arbiter.sv
// Round-robin arbiter in front of the coherency FSMs: grants one request per cycle,
// holds a per-line lock slot until the FSM returns the grant's tag on completion.
module ccu_line_arbiter #(
  parameter int NoPorts      = 2,
  parameter int AddrWidth    = 64,
  parameter int LineOffset   = 6,
  parameter int MaxInflight  = 4,
  localparam int TagWidth     = (MaxInflight > 1) ? $clog2(MaxInflight) : 1,
  localparam int PortIdxWidth = (NoPorts > 1) ? $clog2(NoPorts) : 1
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic [NoPorts-1:0]                req_valid_i,
  input  logic [NoPorts-1:0][AddrWidth-1:0] req_addr_i,
  output logic [NoPorts-1:0]                req_ready_o,
  output logic                              gnt_valid_o,
  input  logic                              gnt_ready_i,
  output logic [PortIdxWidth-1:0]           gnt_port_o,
  output logic [AddrWidth-1:0]              gnt_addr_o,
  output logic [TagWidth-1:0]               gnt_tag_o,
  input  logic                              done_valid_i,
  input  logic [TagWidth-1:0]               done_tag_i,
  output logic [TagWidth:0]                 inflight_o,
  output logic                              busy_o
);

  localparam int LineWidth = AddrWidth - LineOffset;

  // Slot table and grant output register.
  logic [MaxInflight-1:0]  r_occ;
  logic [LineWidth-1:0]    r_line [MaxInflight];
  logic [PortIdxWidth-1:0] r_rr;
  logic                    r_gnt_valid;
  logic [PortIdxWidth-1:0] r_gnt_port;
  logic [AddrWidth-1:0]    r_gnt_addr;
  logic [TagWidth-1:0]     r_gnt_tag;
  logic [TagWidth:0]       r_inflight;

  logic                    w_free_any;
  logic [TagWidth-1:0]     w_free_idx;
  logic [NoPorts-1:0]      w_conflict;
  logic                    w_can_load;
  logic [NoPorts-1:0]      w_elig;
  logic [PortIdxWidth:0]   w_cand;
  logic                    w_found;
  logic [PortIdxWidth-1:0] w_win;
  logic [PortIdxWidth-1:0] w_rr_next;
  logic                    w_done;

  // Descending scan so the lowest free index is the one left standing.
  always_comb begin
    w_free_any = 1'b0;
    w_free_idx = '0;
    for (int s = MaxInflight - 1; s >= 0; s--) begin
      if (!r_occ[s]) begin
        w_free_any = 1'b1;
        w_free_idx = TagWidth'(s);
      end
    end
  end

  always_comb begin
    w_conflict = '0;
    for (int p = 0; p < NoPorts; p++) begin
      for (int s = 0; s < MaxInflight; s++) begin
        if (r_occ[s] && (r_line[s] == req_addr_i[p][AddrWidth-1:LineOffset])) begin
          w_conflict[p] = 1'b1;
        end
      end
    end
  end

  // Nothing loads while reset is held, so req_ready_o stays low under reset.
  assign w_can_load = rst_ni && (!r_gnt_valid || gnt_ready_i) && w_free_any;
  assign w_elig     = req_valid_i & ~w_conflict & {NoPorts{w_can_load}};

  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_cand  = '0;
    for (int i = 0; i < NoPorts; i++) begin
      w_cand = {1'b0, r_rr} + (PortIdxWidth+1)'(i);
      if (w_cand >= (PortIdxWidth+1)'(NoPorts)) begin
        w_cand = w_cand - (PortIdxWidth+1)'(NoPorts);
      end
      if (!w_found && w_elig[w_cand[PortIdxWidth-1:0]]) begin
        w_found = 1'b1;
        w_win   = w_cand[PortIdxWidth-1:0];
      end
    end
  end

  always_comb begin
    req_ready_o = '0;
    if (w_found) begin
      req_ready_o[w_win] = 1'b1;
    end
  end

  assign w_rr_next = (w_win == PortIdxWidth'(NoPorts - 1)) ? '0 : w_win + 1'b1;

  // Completions for slots that are not occupied are dropped.
  assign w_done = done_valid_i && (int'(done_tag_i) < MaxInflight) && r_occ[done_tag_i];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_occ       <= '0;
      for (int s = 0; s < MaxInflight; s++) begin
        r_line[s] <= '0;
      end
      r_rr        <= '0;
      r_gnt_valid <= 1'b0;
      r_gnt_port  <= '0;
      r_gnt_addr  <= '0;
      r_gnt_tag   <= '0;
      r_inflight  <= '0;
    end else begin
      if (w_done) begin
        r_occ[done_tag_i] <= 1'b0;
      end
      if (w_found) begin
        r_occ[w_free_idx]  <= 1'b1;
        r_line[w_free_idx] <= req_addr_i[w_win][AddrWidth-1:LineOffset];
        r_rr               <= w_rr_next;
        r_gnt_valid        <= 1'b1;
        r_gnt_port         <= w_win;
        r_gnt_addr         <= req_addr_i[w_win];
        r_gnt_tag          <= w_free_idx;
      end else if (gnt_ready_i) begin
        r_gnt_valid <= 1'b0;
      end
      case ({w_found, w_done})
        2'b10:   r_inflight <= r_inflight + 1'b1;
        2'b01:   r_inflight <= r_inflight - 1'b1;
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  assign gnt_valid_o = r_gnt_valid;
  assign gnt_port_o  = r_gnt_port;
  assign gnt_addr_o  = r_gnt_addr;
  assign gnt_tag_o   = r_gnt_tag;
  assign inflight_o  = r_inflight;
  assign busy_o      = (r_inflight != '0);

endmodule

// File: tb/tb_ccu_line_arbiter.sv
// Directed bench for ccu_line_arbiter: expected grants are queued when requests are
// driven and compared at the grant handshake; occupancy/ready checked inline.
module tb_ccu_line_arbiter;

  localparam int NoPorts      = 2;
  localparam int AddrWidth    = 64;
  localparam int MaxInflight  = 4;
  localparam int TagWidth     = 2;
  localparam int PortIdxWidth = 1;
  localparam int ExpW         = PortIdxWidth + AddrWidth + TagWidth;

  logic                              clk = 1'b0;
  logic                              rst_n = 1'b0;
  logic [NoPorts-1:0]                req_valid = '0;
  logic [NoPorts-1:0][AddrWidth-1:0] req_addr = '0;
  logic [NoPorts-1:0]                req_ready;
  logic                              gnt_valid;
  logic                              gnt_ready = 1'b1;
  logic [PortIdxWidth-1:0]           gnt_port;
  logic [AddrWidth-1:0]              gnt_addr;
  logic [TagWidth-1:0]               gnt_tag;
  logic                              done_valid = 1'b0;
  logic [TagWidth-1:0]               done_tag = '0;
  logic [TagWidth:0]                 inflight;
  logic                              busy;

  int                n_checks = 0;
  int                n_errors = 0;
  logic [ExpW-1:0]   exp_q[$];
  logic [MaxInflight-1:0] tb_occ = '0;

  ccu_line_arbiter #(
    .NoPorts(NoPorts), .AddrWidth(AddrWidth), .LineOffset(6), .MaxInflight(MaxInflight)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_addr_i(req_addr), .req_ready_o(req_ready),
    .gnt_valid_o(gnt_valid), .gnt_ready_i(gnt_ready), .gnt_port_o(gnt_port),
    .gnt_addr_o(gnt_addr), .gnt_tag_o(gnt_tag),
    .done_valid_i(done_valid), .done_tag_i(done_tag),
    .inflight_o(inflight), .busy_o(busy)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [ExpW-1:0] pack(input int p, input logic [AddrWidth-1:0] a, input int t);
    return {PortIdxWidth'(p), a, TagWidth'(t)};
  endfunction

  // Scoreboard: a grant handshake at negedge pops the oldest expectation.
  task automatic monitor();
    logic [ExpW-1:0] e;
    if (rst_n && gnt_valid && gnt_ready) begin
      check_eq("gnt_expected", 128'(exp_q.size() > 0), 128'(1));
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_eq("gnt_port_addr_tag", 128'({gnt_port, gnt_addr, gnt_tag}), 128'(e));
      end
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic grant_exp(input int p, input logic [AddrWidth-1:0] a, input int t);
    logic [NoPorts-1:0] m;
    m    = '0;
    m[p] = 1'b1;
    check_eq("req_ready_onehot", 128'(req_ready), 128'(m));
    exp_q.push_back(pack(p, a, t));
    tb_occ[t] = 1'b1;
  endtask

  task automatic drive_done(input int t);
    assert (tb_occ[t] == 1'b1) else $error("done on unoccupied tag %0d", t);
    tb_occ[t]  = 1'b0;
    done_valid = 1'b1;
    done_tag   = TagWidth'(t);
  endtask

  task automatic check_reset_outputs();
    check_eq("rst_req_ready", 128'(req_ready), 128'(0));
    check_eq("rst_gnt_valid", 128'(gnt_valid), 128'(0));
    check_eq("rst_gnt_port",  128'(gnt_port),  128'(0));
    check_eq("rst_gnt_addr",  128'(gnt_addr),  128'(0));
    check_eq("rst_gnt_tag",   128'(gnt_tag),   128'(0));
    check_eq("rst_inflight",  128'(inflight),  128'(0));
    check_eq("rst_busy",      128'(busy),      128'(0));
  endtask

  task automatic do_reset();
    req_valid  = '0;
    done_valid = 1'b0;
    gnt_ready  = 1'b1;
    rst_n      = 1'b0;
    exp_q.delete();
    tb_occ     = '0;
    settle();
    check_reset_outputs();
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [AddrWidth-1:0] next_addr;
    int order [4];

    // Power-on reset
    #2;
    check_reset_outputs();
    cyc();
    cyc();
    rst_n = 1'b1;

    // Single request, then its completion
    cyc();
    req_valid = 2'b01; req_addr[0] = 64'h1000;
    settle();
    grant_exp(0, 64'h1000, 0);
    cyc();
    req_valid = '0;
    settle();
    check_eq("single_gnt_valid", 128'(gnt_valid), 128'(1));
    check_eq("single_inflight", 128'(inflight), 128'(1));
    check_eq("single_busy", 128'(busy), 128'(1));
    cyc();
    settle();
    check_eq("single_gnt_clear", 128'(gnt_valid), 128'(0));
    drive_done(0);
    cyc();
    done_valid = 1'b0;
    settle();
    check_eq("single_done_inflight", 128'(inflight), 128'(0));
    check_eq("single_done_busy", 128'(busy), 128'(0));

    // Round-robin across distinct lines until slots run out
    do_reset();
    cyc();
    req_valid = 2'b11; req_addr[0] = 64'h1000; req_addr[1] = 64'h2000;
    next_addr = 64'h3000;
    settle();
    for (int k = 0; k < 4; k++) begin
      int p;
      p = k % 2;
      grant_exp(p, req_addr[p], k);
      cyc();
      req_addr[p] = next_addr;
      next_addr   = next_addr + 64'h1000;
      settle();
    end
    check_eq("rr_full_inflight", 128'(inflight), 128'(MaxInflight));
    for (int k = 0; k < 2; k++) begin
      check_eq("rr_full_stall", 128'(req_ready), 128'(0));
      cyc();
      settle();
    end
    drive_done(1);
    settle();
    check_eq("rr_done_not_comb", 128'(req_ready), 128'(0));
    cyc();
    done_valid = 1'b0;
    settle();
    check_eq("rr_after_done_inflight", 128'(inflight), 128'(3));
    grant_exp(0, 64'h5000, 1);
    cyc();
    req_valid = '0;
    settle();
    check_eq("rr_refill_inflight", 128'(inflight), 128'(MaxInflight));
    order = '{0, 2, 3, 1};
    for (int k = 0; k < 4; k++) begin
      drive_done(order[k]);
      cyc();
    end
    done_valid = 1'b0;
    settle();
    check_eq("rr_drain_inflight", 128'(inflight), 128'(0));

    // Same-line conflict
    cyc();
    req_valid = 2'b01; req_addr[0] = 64'h1000;
    settle();
    grant_exp(0, 64'h1000, 0);
    cyc();
    req_valid = 2'b10; req_addr[1] = 64'h1020;
    settle();
    for (int k = 0; k < 3; k++) begin
      check_eq("conflict_blocked", 128'(req_ready), 128'(0));
      cyc();
      settle();
    end
    drive_done(0);
    settle();
    check_eq("conflict_done_cycle", 128'(req_ready), 128'(0));
    cyc();
    done_valid = 1'b0;
    settle();
    grant_exp(1, 64'h1020, 0);
    cyc();
    req_valid = '0;
    cyc();
    drive_done(0);
    cyc();
    done_valid = 1'b0;

    // Backpressure holds the grant register
    cyc();
    req_valid = 2'b01; req_addr[0] = 64'h7000;
    settle();
    grant_exp(0, 64'h7000, 0);
    cyc();
    req_valid = 2'b10; req_addr[1] = 64'h8000; gnt_ready = 1'b0;
    settle();
    for (int k = 0; k < 5; k++) begin
      check_eq("bp_req_ready", 128'(req_ready), 128'(0));
      check_eq("bp_gnt_valid", 128'(gnt_valid), 128'(1));
      check_eq("bp_gnt_port", 128'(gnt_port), 128'(0));
      check_eq("bp_gnt_addr", 128'(gnt_addr), 128'(64'h7000));
      check_eq("bp_gnt_tag", 128'(gnt_tag), 128'(0));
      cyc();
      settle();
    end
    gnt_ready = 1'b1;
    settle();
    grant_exp(1, 64'h8000, 1);
    cyc();
    req_valid = '0;
    settle();
    check_eq("bp_release_port", 128'(gnt_port), 128'(1));
    cyc();
    drive_done(0);
    cyc();
    drive_done(1);
    cyc();
    done_valid = 1'b0;
    settle();
    check_eq("bp_drain_inflight", 128'(inflight), 128'(0));

    // Done and allocation in the same cycle with all slots full
    for (int k = 0; k < 4; k++) begin
      cyc();
      req_valid   = 2'b01;
      req_addr[0] = 64'h10000 + 64'(k) * 64'h1000;
      settle();
      grant_exp(0, req_addr[0], k);
    end
    cyc();
    req_addr[0] = 64'h20000;
    settle();
    check_eq("coll_full_inflight", 128'(inflight), 128'(MaxInflight));
    drive_done(2);
    settle();
    check_eq("coll_no_grant_on_done", 128'(req_ready), 128'(0));
    cyc();
    done_valid = 1'b0;
    settle();
    grant_exp(0, 64'h20000, 2);
    cyc();
    req_valid = '0;
    settle();
    check_eq("coll_inflight", 128'(inflight), 128'(MaxInflight));
    for (int k = 0; k < 4; k++) begin
      drive_done(k);
      cyc();
    end
    done_valid = 1'b0;
    settle();
    check_eq("coll_drain_inflight", 128'(inflight), 128'(0));

    // Asynchronous reset with three slots busy and a grant pending
    cyc();
    req_valid = 2'b01; req_addr[0] = 64'h30000;
    settle();
    grant_exp(0, 64'h30000, 0);
    cyc();
    req_addr[0] = 64'h31000;
    settle();
    grant_exp(0, 64'h31000, 1);
    cyc();
    req_addr[0] = 64'h32000;
    settle();
    grant_exp(0, 64'h32000, 2);
    cyc();
    req_valid = '0; gnt_ready = 1'b0;
    settle();
    check_eq("pre_rst_gnt_tag", 128'(gnt_tag), 128'(2));
    check_eq("pre_rst_inflight", 128'(inflight), 128'(3));
    req_valid = 2'b01; req_addr[0] = 64'h1000;
    rst_n = 1'b0;
    exp_q.delete();
    tb_occ = '0;
    settle();
    check_reset_outputs();
    cyc();
    cyc();
    rst_n = 1'b1; gnt_ready = 1'b1;
    req_valid = 2'b11; req_addr[1] = 64'h2000;
    settle();
    grant_exp(0, 64'h1000, 0);
    cyc();
    req_valid = '0;
    settle();
    check_eq("post_rst_inflight", 128'(inflight), 128'(1));
    cyc();
    drive_done(0);
    cyc();
    done_valid = 1'b0;
    settle();
    check_eq("post_rst_drain", 128'(inflight), 128'(0));
    check_eq("queue_drained", 128'(exp_q.size()), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Safety net against a stuck run
  initial begin
    #200000;
    n_errors++;
    $display("FAIL timeout: simulation did not complete");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
